// File: rtl/ame_pkg.sv
// Shared definitions for the AME gradient statistics block: default data
// widths and the row-sequencing state encoding.
package ame_pkg;

  localparam int COMP_DATA_BITS_DEF = 8;
  localparam int SUM_DATA_BITS_DEF  = 2 * COMP_DATA_BITS_DEF + 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW_1 = 3'd1,
    ROW_2 = 3'd2,
    ROW_3 = 3'd3,
    ROW_4 = 3'd4
  } state_t;

endpackage

// File: rtl/ame_grad_mac4.sv
// Stateless four-lane signed multiply-accumulate for one row of gradients.
// Each product keeps full precision, is sign-extended (or wrapped) to the
// sum width, and the four lanes are reduced with a balanced adder tree.
module ame_grad_mac4
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = COMP_DATA_BITS_DEF,
  parameter int SUM_DATA_BITS  = SUM_DATA_BITS_DEF
) (
  input  logic [3:0][COMP_DATA_BITS-1:0] i_a,
  input  logic [3:0][COMP_DATA_BITS-1:0] i_b,
  output logic [SUM_DATA_BITS-1:0]       o_sum
);

  localparam int PW = 2 * COMP_DATA_BITS;

  logic signed [PW-1:0]            w_prod [4];
  logic signed [SUM_DATA_BITS-1:0] w_ext  [4];

  // Per-lane signed product, resized to the accumulator width, then summed.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_prod[k] = PW'($signed(i_a[k])) * PW'($signed(i_b[k]));
      w_ext[k]  = SUM_DATA_BITS'(w_prod[k]);
    end
    o_sum = (w_ext[0] + w_ext[1]) + (w_ext[2] + w_ext[3]);
  end

endmodule

// File: rtl/ame_grad_stat.sv
// Gradient structure-tensor statistics over a 4x4 block of Sobel outputs.
// A block is captured on init, then one row per cycle is multiplied and
// accumulated; the sums of gx*gx, gy*gy and gx*gy are published with a
// one-cycle done pulse. A new init in the last row cycle overlaps the next
// block so blocks can stream every four cycles.
module ame_grad_stat
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = COMP_DATA_BITS_DEF,
  parameter int SUM_DATA_BITS  = SUM_DATA_BITS_DEF
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 comp_init_i,
  input  logic [3:0][3:0][COMP_DATA_BITS-1:0]  comp_data_x_i,
  input  logic [3:0][3:0][COMP_DATA_BITS-1:0]  comp_data_y_i,
  output logic                                 comp_done_o,
  output logic [SUM_DATA_BITS-1:0]             stat_xx_o,
  output logic [SUM_DATA_BITS-1:0]             stat_yy_o,
  output logic [SUM_DATA_BITS-1:0]             stat_xy_o
);

  state_t                              r_state;
  logic [3:0][3:0][COMP_DATA_BITS-1:0] r_gx;
  logic [3:0][3:0][COMP_DATA_BITS-1:0] r_gy;
  logic [SUM_DATA_BITS-1:0]            r_acc_xx;
  logic [SUM_DATA_BITS-1:0]            r_acc_yy;
  logic [SUM_DATA_BITS-1:0]            r_acc_xy;

  logic [3:0][COMP_DATA_BITS-1:0]      w_row_x;
  logic [3:0][COMP_DATA_BITS-1:0]      w_row_y;
  logic [SUM_DATA_BITS-1:0]            w_sum_xx;
  logic [SUM_DATA_BITS-1:0]            w_sum_yy;
  logic [SUM_DATA_BITS-1:0]            w_sum_xy;

  // Pick the captured row that belongs to the current row state.
  always_comb begin
    w_row_x = r_gx[0];
    w_row_y = r_gy[0];
    case (r_state)
      ROW_2: begin
        w_row_x = r_gx[1];
        w_row_y = r_gy[1];
      end
      ROW_3: begin
        w_row_x = r_gx[2];
        w_row_y = r_gy[2];
      end
      ROW_4: begin
        w_row_x = r_gx[3];
        w_row_y = r_gy[3];
      end
      default: begin
        w_row_x = r_gx[0];
        w_row_y = r_gy[0];
      end
    endcase
  end

  ame_grad_mac4 #(
    .COMP_DATA_BITS (COMP_DATA_BITS),
    .SUM_DATA_BITS  (SUM_DATA_BITS)
  ) u_mac_xx (
    .i_a   (w_row_x),
    .i_b   (w_row_x),
    .o_sum (w_sum_xx)
  );

  ame_grad_mac4 #(
    .COMP_DATA_BITS (COMP_DATA_BITS),
    .SUM_DATA_BITS  (SUM_DATA_BITS)
  ) u_mac_yy (
    .i_a   (w_row_y),
    .i_b   (w_row_y),
    .o_sum (w_sum_yy)
  );

  ame_grad_mac4 #(
    .COMP_DATA_BITS (COMP_DATA_BITS),
    .SUM_DATA_BITS  (SUM_DATA_BITS)
  ) u_mac_xy (
    .i_a   (w_row_x),
    .i_b   (w_row_y),
    .o_sum (w_sum_xy)
  );

  // Row sequencer: capture, accumulate four rows, publish with a done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_gx        <= '0;
      r_gy        <= '0;
      r_acc_xx    <= '0;
      r_acc_yy    <= '0;
      r_acc_xy    <= '0;
      comp_done_o <= 1'b0;
      stat_xx_o   <= '0;
      stat_yy_o   <= '0;
      stat_xy_o   <= '0;
    end else begin
      comp_done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (comp_init_i) begin
            r_gx    <= comp_data_x_i;
            r_gy    <= comp_data_y_i;
            r_state <= ROW_1;
          end
        end
        ROW_1: begin
          r_acc_xx <= w_sum_xx;
          r_acc_yy <= w_sum_yy;
          r_acc_xy <= w_sum_xy;
          r_state  <= ROW_2;
        end
        ROW_2: begin
          r_acc_xx <= r_acc_xx + w_sum_xx;
          r_acc_yy <= r_acc_yy + w_sum_yy;
          r_acc_xy <= r_acc_xy + w_sum_xy;
          r_state  <= ROW_3;
        end
        ROW_3: begin
          r_acc_xx <= r_acc_xx + w_sum_xx;
          r_acc_yy <= r_acc_yy + w_sum_yy;
          r_acc_xy <= r_acc_xy + w_sum_xy;
          r_state  <= ROW_4;
        end
        ROW_4: begin
          stat_xx_o   <= r_acc_xx + w_sum_xx;
          stat_yy_o   <= r_acc_yy + w_sum_yy;
          stat_xy_o   <= r_acc_xy + w_sum_xy;
          comp_done_o <= 1'b1;
          if (comp_init_i) begin
            r_gx    <= comp_data_x_i;
            r_gy    <= comp_data_y_i;
            r_state <= ROW_1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ame_grad_stat.sv
// Self-checking bench for ame_grad_stat. A scoreboard of expected results
// (cycle of the done pulse plus the three sums) is filled whenever the bench
// issues an init the block is able to accept; every cycle the done flag and
// the statistic outputs are compared against it.
module tb_ame_grad_stat;

  localparam int CW = 8;
  localparam int SW = 20;

  typedef logic [3:0][3:0][CW-1:0] blk_t;

  typedef struct packed {
    int            cyc;
    logic [SW-1:0] xx;
    logic [SW-1:0] yy;
    logic [SW-1:0] xy;
  } exp_t;

  logic          clk;
  logic          rstN;
  logic          init;
  blk_t          gx;
  blk_t          gy;
  logic          done;
  logic [SW-1:0] statXx;
  logic [SW-1:0] statYy;
  logic [SW-1:0] statXy;

  int            checks;
  int            failures;
  int            cyc;
  int            freeAt;
  exp_t          q[$];
  logic [SW-1:0] lastXx;
  logic [SW-1:0] lastYy;
  logic [SW-1:0] lastXy;

  ame_grad_stat #(
    .COMP_DATA_BITS (CW),
    .SUM_DATA_BITS  (SW)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rstN),
    .comp_init_i   (init),
    .comp_data_x_i (gx),
    .comp_data_y_i (gy),
    .comp_done_o   (done),
    .stat_xx_o     (statXx),
    .stat_yy_o     (statYy),
    .stat_xy_o     (statXy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] req);
    checks++;
    assert (obs === req)
    else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, $signed(obs), $signed(req));
    end
  endtask

  // Reference: plain integer sums over the 16 samples, wrapped to SW bits.
  task automatic refSums(input blk_t ax, input blk_t ay,
                         output logic [SW-1:0] rxx, output logic [SW-1:0] ryy,
                         output logic [SW-1:0] rxy);
    int sxx;
    int syy;
    int sxy;
    int a;
    int b;
    sxx = 0;
    syy = 0;
    sxy = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a   = int'($signed(ax[r][c]));
        b   = int'($signed(ay[r][c]));
        sxx += a * a;
        syy += b * b;
        sxy += a * b;
      end
    end
    rxx = SW'(sxx);
    ryy = SW'(syy);
    rxy = SW'(sxy);
  endtask

  task automatic randBlk(output blk_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = CW'($urandom);
  endtask

  // Compare done and the statistic outputs with the scoreboard for this cycle.
  task automatic checkOutput();
    logic expDone;
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
    expDone = (q.size() > 0) && (q[0].cyc == cyc);
    checkVal("done", SW'(done), SW'(expDone));
    if (expDone) begin
      e      = q.pop_front();
      lastXx = e.xx;
      lastYy = e.yy;
      lastXy = e.xy;
    end
    checkVal("stat_xx", statXx, lastXx);
    checkVal("stat_yy", statYy, lastYy);
    checkVal("stat_xy", statXy, lastXy);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    checkOutput();
  endtask

  // Drive init with a block; record an expectation if the block can take it.
  // Done follows 5 cycles after the cycle in which init is driven.
  task automatic applyStimulus(input blk_t ax, input blk_t ay, input bit useExp,
                               input logic [SW-1:0] ex, input logic [SW-1:0] ey,
                               input logic [SW-1:0] exy);
    exp_t e;
    logic [SW-1:0] mx;
    logic [SW-1:0] my;
    logic [SW-1:0] mxy;
    gx   = ax;
    gy   = ay;
    init = 1'b1;
    if (cyc >= freeAt) begin
      if (useExp) begin
        mx  = ex;
        my  = ey;
        mxy = exy;
      end else begin
        refSums(ax, ay, mx, my, mxy);
      end
      e.cyc  = cyc + 5;
      e.xx   = mx;
      e.yy   = my;
      e.xy   = mxy;
      q.push_back(e);
      freeAt = cyc + 4;
    end
  endtask

  task automatic idleInputs();
    blk_t j;
    init = 1'b0;
    randBlk(j);
    gx = j;
    randBlk(j);
    gy = j;
  endtask

  initial begin
    blk_t a;
    blk_t b;
    int   gap;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    freeAt   = 0;
    lastXx   = '0;
    lastYy   = '0;
    lastXy   = '0;
    rstN     = 1'b0;
    init     = 1'b0;
    gx       = '0;
    gy       = '0;

    // Reset state: no done, all statistics zero.
    repeat (3) stepCycle();
    rstN   = 1'b1;
    freeAt = cyc;

    // Unit gx, zero gy, init on the first edge after reset release.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = CW'(1);
        b[r][c] = CW'(0);
      end
    applyStimulus(a, b, 1'b1, SW'(16), SW'(0), SW'(0));
    stepCycle();
    idleInputs();
    repeat (7) stepCycle();

    // Ramp gx = r*4+c with gy = -gx.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = CW'(r * 4 + c);
        b[r][c] = CW'(-(r * 4 + c));
      end
    applyStimulus(a, b, 1'b1, SW'(1240), SW'(1240), SW'(-1240));
    stepCycle();
    idleInputs();
    repeat (6) stepCycle();

    // 8-bit extremes.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = CW'(-128);
        b[r][c] = CW'(127);
      end
    applyStimulus(a, b, 1'b1, SW'(262144), SW'(258064), SW'(-260096));
    stepCycle();
    idleInputs();
    repeat (6) stepCycle();

    // Three back-to-back blocks with init held high through ROW_1..ROW_3.
    for (int k = 0; k < 3; k++) begin
      randBlk(a);
      randBlk(b);
      applyStimulus(a, b, 1'b0, '0, '0, '0);
      for (int s = 0; s < 3; s++) begin
        stepCycle();
        randBlk(a);
        randBlk(b);
        applyStimulus(a, b, 1'b0, '0, '0, '0);
      end
      stepCycle();
    end
    idleInputs();
    repeat (8) stepCycle();

    // Reset during ROW_2 abandons the block; next init works normally.
    randBlk(a);
    randBlk(b);
    applyStimulus(a, b, 1'b0, '0, '0, '0);
    stepCycle();
    idleInputs();
    stepCycle();
    rstN = 1'b0;
    #1;
    checkVal("rst_done", SW'(done), SW'(0));
    checkVal("rst_xx", statXx, SW'(0));
    checkVal("rst_yy", statYy, SW'(0));
    checkVal("rst_xy", statXy, SW'(0));
    q.delete();
    lastXx = '0;
    lastYy = '0;
    lastXy = '0;
    @(negedge clk);
    cyc++;
    rstN   = 1'b1;
    freeAt = cyc;
    randBlk(a);
    randBlk(b);
    applyStimulus(a, b, 1'b0, '0, '0, '0);
    stepCycle();
    idleInputs();
    repeat (7) stepCycle();

    // Random blocks with random gaps and ignored inits mid-block.
    for (int k = 0; k < 1000; k++) begin
      randBlk(a);
      randBlk(b);
      applyStimulus(a, b, 1'b0, '0, '0, '0);
      for (int s = 0; s < 3; s++) begin
        stepCycle();
        if ($urandom_range(0, 1) == 1) begin
          randBlk(a);
          randBlk(b);
          applyStimulus(a, b, 1'b0, '0, '0, '0);
        end else begin
          idleInputs();
        end
      end
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        stepCycle();
        idleInputs();
      end
      stepCycle();
    end
    idleInputs();
    repeat (10) stepCycle();

    // Every expected done pulse must have appeared.
    checkVal("pending", SW'(q.size()), SW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
